predictor_arbiter: RTL and testbench

Shares a single `predictor` instance among `NUM_REQ` requesting cores. Requests are granted in round-robin order. For each request the block holds the operand stable for the predictor's full multi-cycle sequence, pulses its `valid_in` once, captures the one-cycle `valid_out` result and returns it to the owning core. It sits between the core cluster and the predictor; the integration ties the predictor's `reset_n` to `~reset`.

---
 rtl/predictor_arbiter.sv | 179 +++++++++++++++++
 tb/tb_predictor_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/predictor_arbiter.sv
// predictor_arbiter: round-robin share of one multi-cycle predictor among
// NUM_REQ cores. Each granted operand is held on pred_data_in, issued with a
// single pred_valid_in pulse, and the predictor result is returned to the
// owning core as a one-cycle rsp_valid pulse.
// Optional feature macro: PRED_ARB_TIMEOUT_EN (WAIT watchdog; returns
// rsp_error=1, rsp_data=0 after TIMEOUT_CYCLES WAIT cycles without a result).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for a request; combinational grant to RR winner
// S_ISSUE   | pred_valid_in pulse, operand held on pred_data_in
// S_WAIT    | waiting for pred_valid_out (or watchdog expiry)
// S_RESPOND | rsp_valid pulse to the owning core
module predictor_arbiter #(
  parameter int NUM_REQ        = 9,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_error,
  output logic [DATA_W-1:0]         pred_data_in,
  output logic                      pred_valid_in,
  input  logic [DATA_W-1:0]         pred_data_out,
  input  logic                      pred_valid_out,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("predictor_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [DATA_W-1:0]   r_op;
  logic [DATA_W-1:0]   r_rsp;
  logic                w_found;
  logic [IDX_W-1:0]    w_winner;
  logic [DATA_W-1:0]   w_win_data;
  logic                w_accept;

`ifdef PRED_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0]    r_wait_tmr;
  logic                r_err;
`endif

  // Round-robin search: lowest requester at/above rr_ptr, else lowest overall.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_data = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_found    = 1'b1;
        w_winner   = IDX_W'(i);
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(r_rr_ptr))) begin
        w_winner   = IDX_W'(i);
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and strobe outputs.
  always_comb begin
    w_next_state  = r_state;
    req_ready     = '0;
    rsp_valid     = '0;
    pred_valid_in = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = w_found && (w_winner == IDX_W'(i));
        end
        if (w_accept) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        pred_valid_in = 1'b1;
        w_next_state  = S_WAIT;
      end
      S_WAIT: begin
        if (pred_valid_out) w_next_state = S_RESPOND;
`ifdef PRED_ARB_TIMEOUT_EN
        else if (r_wait_tmr == '0) w_next_state = S_RESPOND;
`endif
      end
      S_RESPOND: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          rsp_valid[i] = (r_owner == IDX_W'(i));
        end
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: operand/owner capture on accept, result capture in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_op     <= '0;
      r_rsp    <= '0;
`ifdef PRED_ARB_TIMEOUT_EN
      r_wait_tmr <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= w_win_data;
            r_owner  <= w_winner;
            r_rr_ptr <= (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
          end
        end
        S_ISSUE: begin
`ifdef PRED_ARB_TIMEOUT_EN
          // Down-counter loaded so terminal count lands on the last WAIT cycle.
          r_wait_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
          r_err      <= 1'b0;
`endif
        end
        S_WAIT: begin
          if (pred_valid_out) begin
            r_rsp <= pred_data_out;
          end
`ifdef PRED_ARB_TIMEOUT_EN
          else if (r_wait_tmr == '0) begin
            r_rsp <= '0;
            r_err <= 1'b1;
          end else begin
            r_wait_tmr <= r_wait_tmr - 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign pred_data_in = r_op;
  assign rsp_data     = (r_state == S_RESPOND) ? r_rsp : '0;
`ifdef PRED_ARB_TIMEOUT_EN
  assign rsp_error    = (r_state == S_RESPOND) && r_err;
`else
  assign rsp_error    = 1'b0;
`endif

endmodule

// File: tb/tb_predictor_arbiter.sv
// Testbench for predictor_arbiter: stub predictor (result = operand >> 2,
// fixed 3-cycle pipeline) and a transaction-level reference model that
// predicts grants, strobes and responses from accept time and phase.
module tb_predictor_arbiter;
  localparam int N  = 9;
  localparam int DW = 32;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_v;
  logic [N*DW-1:0] req_d;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_data, pred_data_in, pred_data_out;
  logic            rsp_error, pred_valid_in, pred_valid_out, busy;

  always #5 clk = ~clk;

  predictor_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst), .req_valid(req_v), .req_data(req_d),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .pred_data_in(pred_data_in),
    .pred_valid_in(pred_valid_in), .pred_data_out(pred_data_out),
    .pred_valid_out(pred_valid_out), .busy(busy)
  );

  // Stub predictor: samples data_in one cycle after valid_in, valid_out 3 cycles after valid_in.
  logic          stub_en;
  logic          s1, s2, s3;
  logic [DW-1:0] sd;
  always @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; sd <= '0;
    end else begin
      s1 <= pred_valid_in & stub_en;
      s2 <= s1;
      s3 <= s2;
      if (s1) sd <= pred_data_in >> 2;
    end
  end
  assign pred_valid_out = s3;
  assign pred_data_out  = sd;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int      cyc = 0;
  bit      m_active = 0;
  int      m_acc_cyc = 0;
  int      m_owner = 0;
  int      m_ptr = 0;
  int      m_rsp_ph = 5;
  bit      m_err = 0;
  bit      m_rst_prev = 0;
  logic [DW-1:0] m_op = '0;
  logic [DW-1:0] m_result = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    int ph;
    int win;
    logic [N-1:0] exp_ready, exp_rv;
    logic [DW-1:0] exp_rd;
    logic exp_err, exp_pvi, exp_busy, do_rsp;
    @(negedge clk);
    exp_ready = '0; exp_rv = '0; exp_rd = '0; exp_err = 1'b0;
    exp_pvi = 1'b0; exp_busy = 1'b0; do_rsp = 1'b0; win = -1; ph = 0;
    if (m_active) begin
      ph       = cyc - m_acc_cyc;
      exp_pvi  = (ph == 1);
      exp_busy = (ph >= 1);
      if (ph == m_rsp_ph) begin
        do_rsp = 1'b1;
        exp_rv[m_owner] = 1'b1;
        exp_rd  = m_err ? '0 : m_result;
        exp_err = m_err;
      end
    end
    if (!m_active || ph == 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && req_v[j]) win = j;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("pred_valid_in", 32'(pred_valid_in), 32'(exp_pvi));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
    chk("pred_data_in", pred_data_in, m_op);
    if (do_rsp || m_rst_prev) chk("rsp_data", rsp_data, exp_rd);
    // Advance the model across the coming edge.
    m_rst_prev = rst;
    if (rst) begin
      m_active = 0; m_ptr = 0; m_op = '0; win = -1;
    end else if (do_rsp) begin
      m_active = 0; win = -1;
    end else if (!m_active && win >= 0) begin
      m_active  = 1;
      m_acc_cyc = cyc;
      m_owner   = win;
      m_ptr     = (win + 1) % N;
      m_op      = req_d[win*DW +: DW];
      m_result  = m_op >> 2;
      m_err     = !stub_en;
`ifdef PRED_ARB_TIMEOUT_EN
      m_rsp_ph  = stub_en ? 5 : TO + 2;
`else
      m_rsp_ph  = stub_en ? 5 : 32'h7fff_ffff;
`endif
    end else begin
      win = -1;
    end
    @(posedge clk);
    #1;
    if (win >= 0) req_v[win] = 1'b0;
    cyc++;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && (m_active || req_v != '0); n++) cycle();
    chk("drain_timeout", {30'd0, m_active, |req_v}, 32'd0);
    cycle();
  endtask

  task automatic request(input int core, input logic [DW-1:0] data);
    req_v[core] = 1'b1;
    req_d[core*DW +: DW] = data;
  endtask

  initial begin
    rst = 1'b1; req_v = '0; req_d = '0; stub_en = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;
    cycle();

    // Single request from core 3: 0x10 -> 0x4 after 5 cycles.
    request(3, 32'h0000_0010);
    wait_idle();

    // Full contention from reset: grants 0..8, one every 6 cycles.
    rst = 1'b1;
    for (int i = 0; i < N; i++) request(i, 32'h0100_0000 * i + 32'h40 + i);
    cycle();
    rst = 1'b0;
    wait_idle();

    // Round-robin wrap cases.
    request(5, 32'h55);        wait_idle();
    request(1, 32'h11); request(7, 32'h77); wait_idle();
    request(8, 32'h88);        wait_idle();
    request(0, 32'hA0); request(8, 32'hA8); wait_idle();

    // Busy blocking: core 2 arrives while core 4 is in WAIT.
    request(4, 32'h444);
    repeat (2) cycle();
    request(2, 32'h222);
    wait_idle();

    // Reset in cycle 3 of a transaction, then core 6 with rr_ptr back at 0.
    request(0, 32'hDEAD_BEEF);
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    request(6, 32'h6666_0000);
    wait_idle();

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 7) == 0) request(i, $urandom);
      end
      cycle();
    end
    wait_idle();

    // Predictor that never answers.
    stub_en = 1'b0;
    request($urandom_range(0, N - 1), $urandom);
`ifdef PRED_ARB_TIMEOUT_EN
    wait_idle();
`else
    repeat (40) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
`endif
    stub_en = 1'b1;
    request(2, 32'h0000_0100);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
